// File: rtl/relu3_pkg.sv
// Shared types and lane helpers for the layer-3 ReLU stream controller.
package relu3_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned LANE_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef logic signed [LANE_W-1:0] lane_t;
  typedef lane_t [NUM_CH-1:0]       lanes_t;

  function automatic lanes_t unpack_lanes(input logic [NUM_CH*LANE_W-1:0] v);
    return lanes_t'(v);
  endfunction

  function automatic logic [NUM_CH*LANE_W-1:0] pack_lanes(input lanes_t l);
    return l;
  endfunction

endpackage

// File: rtl/relu3_skid_fifo.sv
// Two-entry FIFO carrying an activated vector plus its end-of-frame tag.
module relu3_skid_fifo #(
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_wlast,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_rlast,
  output logic [1:0]    o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_data [2];
  logic [1:0]    r_last;
  logic          r_wr;
  logic          r_rd;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_rdata = r_data[r_rd];
  assign o_rlast = r_last[r_rd];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage is cleared on reset so the visible head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last    <= '0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr] <= i_wdata;
        r_last[r_wr] <= i_wlast;
        r_wr         <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/relu3_stream_ctrl.sv
// Layer-3 activation sequencer: frames SEQ vectors, applies per-lane ReLU, streams via a skid FIFO.
module relu3_stream_ctrl
  import relu3_pkg::*;
#(
  parameter int unsigned WIDTH  = relu3_pkg::LANE_W,
  parameter int unsigned NUM_CH = relu3_pkg::NUM_CH,
  parameter int unsigned LEN_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic [LEN_W-1:0]        pos_in
);

  localparam logic [LEN_W-1:0] One = LEN_W'(1);

  state_t                  r_state;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_pos;
  logic [NUM_CH*WIDTH-1:0] w_relu;
  logic                    w_accept;
  logic                    w_pop;
  logic                    w_is_last;
  logic                    w_fifo_last;
  logic [1:0]              w_count;
  logic                    w_full;
  logic                    w_empty;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_relu
    assign w_relu[i*WIDTH +: WIDTH] = in_data[i*WIDTH + WIDTH - 1] ? '0 : in_data[i*WIDTH +: WIDTH];
  end

  assign in_ready  = (r_state == RUN) && (r_pos < r_len) && !w_full;
  assign w_accept  = in_valid && in_ready;
  assign w_is_last = (r_pos == r_len - One);
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign out_last  = out_valid && w_fifo_last;
  assign busy      = (r_state == RUN) || (r_state == DRAIN);
  assign done      = (r_state == DONE);
  assign pos_in    = r_pos;

  relu3_skid_fifo #(
    .DW (NUM_CH*WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_wdata (w_relu),
    .i_wlast (w_is_last),
    .i_pop   (w_pop),
    .o_rdata (out_data),
    .o_rlast (w_fifo_last),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_pos   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_len   <= cfg_len;
            r_pos   <= '0;
            r_state <= (cfg_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          // in_ready already guarantees r_pos < r_len, so the increment saturates at r_len.
          if (w_accept) begin
            r_pos <= r_pos + One;
            if (w_is_last) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop && w_fifo_last) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/relu3_stream_ctrl.md
Name: relu3_stream_ctrl

Overview:
Sequencing controller for the layer-3 activation stage of the 1-D CNN ECG pipeline. Accepts one 8-channel conv3 result vector per time step over a valid/ready handshake and applies ReLU to all 8 lanes. Buffers results in a 2-entry skid FIFO and streams them to the next stage (pool/feature buffer). Frames each run of SEQ positions with start/last/done, so the top-level FSM can launch layer 3 and wait for completion.

Parameters:
WIDTH, 8, signed lane width of input and output samples
NUM_CH, 8, channels per vector (fixed by layer 3; only 8 supported)
LEN_W, 10, width of the sequence-length config and position counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle launch pulse, honoured only in IDLE
cfg_len  in  LEN_W  positions per frame, sampled on an accepted start
in_valid  in  1  conv3 vector valid
in_ready  out  1  controller can accept a vector this cycle
in_data  in  NUM_CH*WIDTH  packed signed lanes, lane 0 in LSBs
out_valid  out  1  activated vector valid
out_ready  in  1  downstream accepts
out_data  out  NUM_CH*WIDTH  packed ReLU results, lane 0 in LSBs
out_last  out  1  high with the vector at position len-1
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse at frame completion
pos_in  out  LEN_W  count of vectors accepted in the current frame

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst. Reset, including mid-frame, forces IDLE, clears the FIFO and counters, and drives in_ready, out_valid, out_last, busy, done, pos_in and out_data to 0. In-flight data is discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start with cfg_len != 0. The length is latched to len_q and pos_in is cleared.
- IDLE -> DONE on start with cfg_len == 0. done pulses on the next cycle and no beats occur.
- RUN -> DRAIN in the cycle the beat with pos_in == len_q-1 is accepted.
- DRAIN -> DONE when the last beat completes its output handshake.
- DONE -> IDLE after exactly one cycle. done = 1 only while in DONE.
- start outside IDLE is ignored.
- in_ready = (state == RUN) && (pos_in < len_q) && (FIFO count < 2). This is registered-friendly: it depends only on state/counters, not on out_ready.
- An input beat is accepted when in_valid && in_ready. pos_in increments per accepted beat and saturates at len_q.
- ReLU per lane: negative -> 0, otherwise pass unchanged. The result is applied before FIFO write and reuses the team's combinational RELU cell ×NUM_CH. No width growth.
- Latency: with the FIFO empty, out_valid rises 1 cycle after acceptance. Sustained throughput is 1 vector/cycle while out_ready = 1.
- FIFO: 2 entries. Simultaneous write and read when count = 2 is not possible, since in_ready is low. When count = 1, simultaneous push and pop leave count = 1.
- out_data and out_last are stable while out_valid && !out_ready. out_last is stored per entry as a tag bit.
- Extra in_valid after the last beat is not accepted (in_ready = 0) and is not an error.

Decomposition:
- relu3_pkg: NUM_CH constant, state_t enum {IDLE, RUN, DRAIN, DONE}, lane_t (signed [WIDTH-1:0]), helper function for lane pack/unpack.
- One sub-module: relu3_skid_fifo, a 2-entry data+last FIFO with count, push/pop and full/empty.
- The FSM, counters and ReLU lanes stay in the top module.

Test Plan:
- Reset then start, cfg_len = 4. Inputs with lane0 = -5, 7, -128, 127 and other lanes = 3, with out_ready = 1. Expect outputs with lane0 = 0, 7, 0, 127 and other lanes = 3. out_last only on beat 4; done pulses 1 cycle after beat 4 out; pos_in = 4.
- Backpressure: cfg_len = 6, out_ready = 0 for 5 cycles. Expect exactly 2 beats accepted, in_ready = 0 thereafter, out_data held stable. After out_ready = 1, all 6 beats arrive in order with no loss or duplicates.
- cfg_len = 0 with start: done pulses on the next cycle and in_valid is never accepted. start during RUN (cfg_len = 3 on the second start) is ignored and the frame length stays the first value.
- Reset asserted mid-frame after 2 of 5 beats, with 1 beat held in the FIFO. Next cycle: all outputs are 0, state IDLE, no stale beat emitted after a fresh start with cfg_len = 1.
- Random in_valid/out_ready (50%), cfg_len = 100, random signed data. Scoreboard checks per-lane max(x, 0), exactly 100 output beats, a single out_last and a single done pulse.
